z_step_out: RTL

// - Z-axis driver output stage, directly downstream of the Z jog/adjust block and the plot engine.
// - Selects one step/dir source and turns each rising step edge into one clean driver pulse.

---
 rtl/z_step_out.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/z_step_out.sv
// Z-axis driver output stage: source select, step-edge to timed driver pulse, position tracking.
// Define ZSTEP_SOFTLIM_EN to drop requests that would move past POS_MIN/POS_MAX.
module z_step_out #(
  parameter int PULSE_W   = 100,
  parameter int LOW_W     = 100,
  parameter int DIR_SETUP = 250,
  parameter int POS_W     = 16,
  parameter int POS_MIN   = -16000,
  parameter int POS_MAX   = 16000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    src_jog,
  input  logic                    jog_step,
  input  logic                    jog_dir,
  input  logic                    plt_step,
  input  logic                    plt_dir,
  input  logic                    zero,
  input  logic                    clr,
  output logic                    step_out,
  output logic                    dir_out,
  output logic                    busy,
  output logic signed [POS_W-1:0] pos,
  output logic                    overrun,
  output logic                    lim_hit
);

  localparam int CNT_MAX_A = (PULSE_W > LOW_W) ? PULSE_W : LOW_W;
  localparam int CNT_MAX   = (CNT_MAX_A > DIR_SETUP) ? CNT_MAX_A : DIR_SETUP;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

`ifdef ZSTEP_SOFTLIM_EN
  localparam bit LIM_EN = 1'b1;
`else
  localparam bit LIM_EN = 1'b0;
`endif

  localparam logic signed [POS_W-1:0] PMIN = POS_W'(POS_MIN);
  localparam logic signed [POS_W-1:0] PMAX = POS_W'(POS_MAX);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_PULSE, S_LOW} state_t;

  typedef struct packed {
    logic vld;
    logic dir;
  } pend_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             prev;
  logic             src_q;
  logic             cur_dir;
  pend_t            pend;

  logic sel_step, sel_dir, src_chg, req;
  logic lim_up, lim_dn, req_blk, req_ok;
  logic pend_ok, pend_blk;
  logic go, go_dir;
  logic pos_upd;
  logic signed [POS_W-1:0] pos_delta;

  assign busy     = (state != S_IDLE);
  assign sel_step = src_jog ? jog_step : plt_step;
  assign sel_dir  = src_jog ? jog_dir  : plt_dir;
  // On a source switch prev still holds the old source's level, so edge detect is masked.
  assign src_chg  = src_jog ^ src_q;
  assign req      = sel_step & ~prev & ~src_chg;

  assign lim_up   = LIM_EN & (pos >= PMAX);
  assign lim_dn   = LIM_EN & (pos <= PMIN);
  assign req_blk  = req & (sel_dir ? lim_up : lim_dn);
  assign req_ok   = req & ~req_blk;
  assign pend_ok  = pend.vld & ~src_chg;
  assign pend_blk = pend.dir ? lim_up : lim_dn;

  // In IDLE the pending entry is older than a fresh request, so it goes first.
  assign go     = pend_ok ? ~pend_blk : req_ok;
  assign go_dir = pend_ok ? pend.dir  : sel_dir;

  assign pos_upd   = (state == S_PULSE) && (cnt == '0);
  assign pos_delta = cur_dir ? {{(POS_W-1){1'b0}}, 1'b1} : {POS_W{1'b1}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev  <= 1'b0;
      src_q <= 1'b0;
    end else begin
      prev  <= sel_step;
      src_q <= src_jog;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend    <= '0;
      overrun <= 1'b0;
      lim_hit <= 1'b0;
    end else begin
      if (src_chg)
        pend <= '0;
      else if (!busy && pend.vld)
        pend <= '{vld: req_ok, dir: sel_dir};
      else if (busy && req_ok && !pend.vld)
        pend <= '{vld: 1'b1, dir: sel_dir};

      if (busy && req_ok && pend.vld)
        overrun <= 1'b1;
      else if (clr)
        overrun <= 1'b0;

      lim_hit <= req_blk | (~busy & pend_ok & pend_blk);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      cur_dir  <= 1'b0;
      step_out <= 1'b0;
      dir_out  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (go) begin
            cur_dir <= go_dir;
            if (go_dir != dir_out) begin
              dir_out <= go_dir;
              cnt     <= CNT_W'(DIR_SETUP - 1);
              state   <= S_SETUP;
            end else begin
              step_out <= 1'b1;
              cnt      <= CNT_W'(PULSE_W - 1);
              state    <= S_PULSE;
            end
          end
        end
        S_SETUP: begin
          if (cnt == '0) begin
            step_out <= 1'b1;
            cnt      <= CNT_W'(PULSE_W - 1);
            state    <= S_PULSE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_PULSE: begin
          if (cnt == '0) begin
            step_out <= 1'b0;
            cnt      <= CNT_W'(LOW_W - 1);
            state    <= S_LOW;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_LOW: begin
          if (cnt == '0)
            state <= S_IDLE;
          else
            cnt <= cnt - 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // zero has priority over a landing step update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pos <= '0;
    else if (zero)
      pos <= '0;
    else if (pos_upd)
      pos <= pos + pos_delta;
  end

endmodule
